// File: rtl/pipe_regfile_sweep.sv
// pipe_regfile_sweep: parametrised register file for the pipelined core.
// One write port (rising clk), two combinational read ports, one indexed
// debug read port, and a synchronous clear sweep that zeroes one register
// per cycle while busy is high.
// Optional feature macro: PIPE_REGFILE_BYPASS_EN enables the same-cycle
// write-to-read bypass on ports A and B (the debug port is never bypassed).
module pipe_regfile_sweep #(
    parameter int WIDTH    = 32,
    parameter int AW       = 5,
    parameter int ZERO_REG = 1
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             clr,
    output logic             busy,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr_a,
    output logic [WIDTH-1:0] rdata_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_b,
    input  logic [AW-1:0]    dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);

    localparam int NREGS = 2 ** AW;

    // The index is one bit wider than an address so that stepping past the
    // last register never wraps back onto register 0.
    localparam logic [AW:0] FIRST_IDX = (ZERO_REG != 0) ? (AW + 1)'(1) : '0;
    localparam logic [AW:0] LAST_IDX  = (AW + 1)'(NREGS - 1);

`ifdef PIPE_REGFILE_BYPASS_EN
    localparam bit BYPASS_EN = 1'b1;
`else
    localparam bit BYPASS_EN = 1'b0;
`endif

    typedef enum logic {
        ST_IDLE,
        ST_SWEEP
    } state_e;

    state_e           state_q, state_d;
    logic [AW:0]      idx_q, idx_d;
    logic [WIDTH-1:0] regs_q [NREGS];
    logic             waddr_ok;
    logic             wr_en;

    // A write lands only when idle and the target is not the hardwired zero.
    assign waddr_ok = !((ZERO_REG != 0) && (waddr == '0));
    assign wr_en    = we && (state_q == ST_IDLE) && waddr_ok;

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // the pre-edge values of its inputs regardless of block ordering.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: start on clr when idle, finish after the last index.
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (clr)                state_d = ST_SWEEP;
            ST_SWEEP: if (idx_q == LAST_IDX)  state_d = ST_IDLE;
            default:                          state_d = ST_IDLE;
        endcase
    end

    // Output logic: busy is a pure function of the state.
    always_comb begin
        busy = (state_q == ST_SWEEP);
    end

    // Sweep index next value: load the first clearable register on start,
    // advance by one on every sweep cycle, hold otherwise.
    always_comb begin
        idx_d = idx_q;
        if (state_q == ST_IDLE && clr) begin
            idx_d = FIRST_IDX;
        end else if (state_q == ST_SWEEP) begin
            idx_d = idx_q + 1'b1;
        end
    end

    // Sweep index register.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    // Register storage: sweep clears take priority; writes only when idle.
    // NOTE: the array is reset because the architecture requires all
    // registers to read zero straight out of reset; this forces flops rather
    // than a RAM macro, which is acceptable at this size.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (state_q == ST_SWEEP) begin
            regs_q[idx_q[AW-1:0]] <= '0;
        end else if (wr_en) begin
            regs_q[waddr] <= wdata;
        end
    end

    // Read ports: zero-register rule first, then optional same-cycle bypass.
    always_comb begin
        rdata_a  = regs_q[raddr_a];
        rdata_b  = regs_q[raddr_b];
        dbg_data = regs_q[dbg_addr];

        if ((ZERO_REG != 0) && (raddr_a == '0)) begin
            rdata_a = '0;
        end else if (BYPASS_EN && wr_en && (waddr == raddr_a)) begin
            rdata_a = wdata;
        end

        if ((ZERO_REG != 0) && (raddr_b == '0)) begin
            rdata_b = '0;
        end else if (BYPASS_EN && wr_en && (waddr == raddr_b)) begin
            rdata_b = wdata;
        end

        if ((ZERO_REG != 0) && (dbg_addr == '0)) begin
            dbg_data = '0;
        end
    end

endmodule

// File: tb/tb_pipe_regfile_sweep.sv
// Testbench for pipe_regfile_sweep: directed scenarios plus randomized
// traffic, checked by a scoreboard against a behavioural reference model.
module tb_pipe_regfile_sweep;

    localparam int WIDTH    = 32;
    localparam int AW       = 5;
    localparam int ZERO_REG = 1;
    localparam int NREGS    = 2 ** AW;
    localparam int SWEEP_LEN = NREGS - ZERO_REG;

`ifdef PIPE_REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic             clk;
    logic             arst_n;
    logic             clr;
    logic             busy;
    logic             we;
    logic [AW-1:0]    waddr;
    logic [WIDTH-1:0] wdata;
    logic [AW-1:0]    raddr_a;
    logic [WIDTH-1:0] rdata_a;
    logic [AW-1:0]    raddr_b;
    logic [WIDTH-1:0] rdata_b;
    logic [AW-1:0]    dbg_addr;
    logic [WIDTH-1:0] dbg_data;

    pipe_regfile_sweep #(
        .WIDTH   (WIDTH),
        .AW      (AW),
        .ZERO_REG(ZERO_REG)
    ) dut (
        .clk     (clk),
        .arst_n  (arst_n),
        .clr     (clr),
        .busy    (busy),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .raddr_a (raddr_a),
        .rdata_a (rdata_a),
        .raddr_b (raddr_b),
        .rdata_b (rdata_b),
        .dbg_addr(dbg_addr),
        .dbg_data(dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] d;
        logic             busy;
        string            name;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: plain array plus count of sweep cycles remaining.
    logic [WIDTH-1:0] mem [NREGS];
    int               sweep_left = 0;

    task automatic check(input string name, input logic [WIDTH-1:0] act,
                         input logic [WIDTH-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    function automatic logic writable(input logic [AW-1:0] addr);
        return !(ZERO_REG != 0 && addr == 0);
    endfunction

    function automatic logic [WIDTH-1:0] stored(input logic [AW-1:0] addr);
        if (!writable(addr)) return '0;
        return mem[addr];
    endfunction

    function automatic logic [WIDTH-1:0] port_read(input logic [AW-1:0] addr);
        if (BYP && arst_n && we && sweep_left == 0 && waddr == addr && writable(addr))
            return wdata;
        return stored(addr);
    endfunction

    // One clock cycle: predict outputs for the inputs now applied, hand the
    // prediction to the monitor, then advance the model across the edge.
    task automatic step(input string name);
        exp_t e;
        if (!arst_n) begin
            for (int i = 0; i < NREGS; i++) mem[i] = '0;
            sweep_left = 0;
        end
        e.a    = port_read(raddr_a);
        e.b    = port_read(raddr_b);
        e.d    = stored(dbg_addr);
        e.busy = (sweep_left > 0);
        e.name = name;
        exp_q.push_back(e);
        @(posedge clk);
        if (arst_n) begin
            if (sweep_left > 0) begin
                mem[NREGS - sweep_left] = '0;
                sweep_left--;
            end else begin
                if (we && writable(waddr)) mem[waddr] = wdata;
                if (clr) sweep_left = SWEEP_LEN;
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        we = 1'b0; clr = 1'b0; waddr = '0; wdata = '0;
    endtask

    // Monitor: compares the DUT outputs on each falling edge against the
    // oldest outstanding prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check({e.name, ".rdata_a"}, rdata_a, e.a);
                check({e.name, ".rdata_b"}, rdata_b, e.b);
                check({e.name, ".dbg_data"}, dbg_data, e.d);
                check({e.name, ".busy"}, {{(WIDTH-1){1'b0}}, busy}, {{(WIDTH-1){1'b0}}, e.busy});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int busy_cnt;
        for (int i = 0; i < NREGS; i++) mem[i] = '0;
        arst_n = 1'b0;
        idle_inputs();
        raddr_a = '0; raddr_b = '0; dbg_addr = '0;
        @(posedge clk);
        #1;

        // Reset: held low two cycles, sweeping the read addresses.
        for (int i = 0; i < 2; i++) begin
            raddr_a = AW'(i + 3); raddr_b = AW'(i + 9); dbg_addr = AW'(i + 17);
            step("reset");
        end
        arst_n = 1'b1;
        for (int i = 0; i < NREGS; i++) begin
            raddr_a = AW'(i); raddr_b = AW'(NREGS - 1 - i); dbg_addr = AW'(i);
            step("reset_all");
        end

        // Write then read back.
        we = 1'b1; waddr = 5; wdata = 32'hDEADBEEF; raddr_a = 1; raddr_b = 2; dbg_addr = 3;
        step("write5");
        idle_inputs(); raddr_a = 5; dbg_addr = 5;
        step("read5");

        // Same-cycle read of the address being written.
        we = 1'b1; waddr = 7; wdata = 32'h12345678; raddr_a = 7; raddr_b = 7; dbg_addr = 7;
        step("bypass7");
        idle_inputs();
        step("after7");

        // Zero register ignores writes.
        we = 1'b1; waddr = 0; wdata = 32'hFFFFFFFF; raddr_a = 0; raddr_b = 0; dbg_addr = 0;
        step("zero_wr");
        idle_inputs();
        step("zero_rd");

        // Fill regs 1..31 with their index.
        for (int i = 1; i < NREGS; i++) begin
            we = 1'b1; waddr = AW'(i); wdata = WIDTH'(i);
            raddr_a = AW'(i); raddr_b = AW'(i - 1); dbg_addr = AW'(i);
            step("fill");
        end
        idle_inputs();

        // Clear sweep with a dropped write and an ignored clr mid-way.
        clr = 1'b1;
        step("clr");
        clr = 1'b0;
        busy_cnt = 0;
        for (int k = 1; k <= SWEEP_LEN + 3; k++) begin
            if (busy) busy_cnt++;
            raddr_a = AW'(k % NREGS); raddr_b = 20; dbg_addr = AW'($urandom_range(0, NREGS - 1));
            we  = (k == 12);
            waddr = 3; wdata = 32'hA5A5A5A5;
            clr = (k == 14);
            step("sweep");
        end
        idle_inputs();
        check("busy_len", WIDTH'(busy_cnt), WIDTH'(SWEEP_LEN));
        for (int i = 0; i < NREGS; i++) begin
            raddr_a = AW'(i); raddr_b = AW'(i); dbg_addr = AW'(i);
            step("post_sweep");
        end

        // Refill, then reset in the middle of a sweep.
        for (int i = 1; i < NREGS; i++) begin
            we = 1'b1; waddr = AW'(i); wdata = $urandom;
            step("refill");
        end
        idle_inputs();
        clr = 1'b1;
        step("clr2");
        clr = 1'b0;
        for (int k = 1; k < 15; k++) begin
            raddr_a = AW'(k); raddr_b = 25; dbg_addr = 30;
            step("sweep2");
        end
        arst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            raddr_a = 25; raddr_b = 30; dbg_addr = 20;
            step("mid_reset");
        end
        arst_n = 1'b1;
        for (int i = 1; i < NREGS; i++) begin
            we = 1'b1; waddr = AW'(i); wdata = $urandom;
            step("refill2");
        end
        idle_inputs();
        clr = 1'b1;
        step("clr3");
        clr = 1'b0;
        busy_cnt = 0;
        for (int k = 1; k <= SWEEP_LEN + 2; k++) begin
            if (busy) busy_cnt++;
            raddr_a = AW'($urandom_range(0, NREGS - 1)); raddr_b = 31; dbg_addr = AW'(k % NREGS);
            step("sweep3");
        end
        check("busy_len2", WIDTH'(busy_cnt), WIDTH'(SWEEP_LEN));

        // Randomized traffic with occasional clear requests.
        for (int n = 0; n < 600; n++) begin
            we       = ($urandom_range(0, 3) != 0);
            waddr    = AW'($urandom_range(0, NREGS - 1));
            wdata    = $urandom;
            clr      = ($urandom_range(0, 59) == 0);
            raddr_a  = ($urandom_range(0, 2) == 0) ? waddr : AW'($urandom_range(0, NREGS - 1));
            raddr_b  = ($urandom_range(0, 2) == 0) ? waddr : AW'($urandom_range(0, NREGS - 1));
            dbg_addr = ($urandom_range(0, 2) == 0) ? waddr : AW'($urandom_range(0, NREGS - 1));
            step("random");
        end
        idle_inputs();

        // Let the monitor drain the remaining predictions.
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d predictions left, expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_regfile_sweep.md
Name: pipe_regfile_sweep

Overview:
- Parametrised successor to the processor's fixed 32x32 register file, used by the pipelined core.
- Write-back stage on the clock's rising edge; two combinational read ports feed the decode stage.
- Write-to-read bypass removes the inverted-clock write.
- Indexed debug read port replaces the fixed r2..r7 debug taps.
- Adds a synchronous multi-cycle clear sweep with a busy flag.

Parameters:
- WIDTH, 32, data width in bits.
- AW, 5, address width; register count NREGS = 2**AW.
- ZERO_REG, 1, when 1 register 0 reads as 0 and ignores writes; when 0 it is an ordinary register.

Ports:
- clk  input  1  rising-edge clock.
- arst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous clear request, single-cycle pulse.
- busy  output  1  high while the clear sweep runs.
- we  input  1  write enable.
- waddr  input  AW  write address.
- wdata  input  WIDTH  write data.
- raddr_a  input  AW  read port A address.
- rdata_a  output  WIDTH  read port A data.
- raddr_b  input  AW  read port B address.
- rdata_b  output  WIDTH  read port B data.
- dbg_addr  input  AW  debug read address.
- dbg_data  output  WIDTH  debug read data; never bypassed.

Behaviour:
- Reset: arst_n low clears all NREGS registers to 0, sets FSM to IDLE, busy=0 and sweep index=0. It acts immediately, mid-sweep included. Read outputs then reflect zeros combinationally.
- Write: on rising clk, when we=1, FSM=IDLE and the address is writable, reg[waddr] <= wdata. When ZERO_REG=1, a write to address 0 is dropped.
- Reads: combinational, zero latency.
  - rdata_x = reg[raddr_x], except with ZERO_REG=1 and raddr_x=0 the output is 0.
  - dbg_data = reg[dbg_addr] with the same zero rule.
- Bypass: when we=1, FSM=IDLE, waddr==raddr_x and the address is writable, rdata_x = wdata in the same cycle. Ports A and B are bypassed independently; both may hit the same waddr.
- FSM states: IDLE, SWEEP.
  - IDLE -> SWEEP on clr=1 at a rising edge. The sweep index loads ZERO_REG (the first register to clear) and busy goes 1 in the next cycle.
  - SWEEP: each rising edge writes 0 to reg[index] and increments the index.
  - On the edge that clears index NREGS-1 the FSM returns to IDLE; busy is 0 from the following cycle.
  - Sweep length is NREGS-ZERO_REG cycles (31 with defaults).
- Simultaneous events:
  - clr and we in the same IDLE cycle: the write is performed and the sweep starts. That register is cleared later by the sweep.
  - we during SWEEP: write dropped, no bypass.
  - clr during SWEEP: ignored; the sweep is not restarted.
  - Reads during SWEEP return current contents: registers below the index are 0, the rest hold old values.
- Index arithmetic is AW+1 bits, so the termination compare against NREGS-1 does not wrap.

Optional Feature:
- Macro: PIPE_REGFILE_BYPASS_EN.
- Defined: write-to-read bypass as described under Behaviour.
- Undefined: no bypass. A read of the address being written returns the old stored value; the new value is visible from the next cycle. The pipeline must then stall or forward externally.
- dbg_data is unaffected either way.

Test Plan:
- Reset: arst_n low for 2 cycles, then high. All of rdata_a, rdata_b, dbg_data read 0 for every address; busy=0.
- Write then read: we=1, waddr=5, wdata=0xDEADBEEF. Next cycle raddr_a=5 gives 0xDEADBEEF and dbg_addr=5 gives 0xDEADBEEF.
- Bypass, same cycle: we=1, waddr=7, wdata=0x12345678, raddr_a=raddr_b=7.
  - With PIPE_REGFILE_BYPASS_EN: both ports show 0x12345678 that cycle.
  - Without it: both show the old value 0, and 0x12345678 the next cycle.
- Zero register: we=1, waddr=0, wdata=0xFFFFFFFF with raddr_a=0. rdata_a=0 in that cycle and afterwards.
- Clear sweep:
  - Setup: fill regs 1..31 with their index, pulse clr.
  - busy goes high for 31 cycles.
  - Mid-sweep (cycle 10): regs 1..10 read 0 and reg 20 reads 20.
  - we=1 to reg 3 during the sweep is dropped.
  - After busy falls, all registers read 0.
- Reset mid-sweep: assert arst_n low at sweep cycle 15. busy drops immediately and all registers read 0. A new clr after release runs a full 31-cycle sweep.
